sp_ramp_gen: RTL and testbench



---
 rtl/mps_ramp_pkg.sv | 14 +
 rtl/sp_ramp_tick.sv | 44 ++++
 rtl/sp_ramp_gen.sv | 167 ++++++++++++++++
 tb/tb_sp_ramp_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mps_ramp_pkg.sv
// Shared types for the MPS set-point ramp path: FSM state encoding and default widths.
package mps_ramp_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sp_ramp_tick.sv
// Interval counter for the ramp: clear, count-enable and compare-to-period.
// With SP_RAMP_DBG_EN defined the live count is exported on o_cnt.
module sp_ramp_tick #(
  parameter int CW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [CW-1:0] i_period,
  output logic          o_expired
`ifdef SP_RAMP_DBG_EN
  ,
  output logic [CW-1:0] o_cnt
`endif
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q >= i_period);

`ifdef SP_RAMP_DBG_EN
  assign o_cnt = cnt_q;
`endif

endmodule

// File: rtl/sp_ramp_gen.sv
// Set-point ramp generator: steps o_set_point toward a commanded target at a fixed interval.
// SP_RAMP_DBG_EN adds o_dbg_cnt / o_dbg_diff / o_dbg_target observation ports.
module sp_ramp_gen
  import mps_ramp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_target,
  input  logic [DW-1:0] i_step,
  input  logic [CW-1:0] i_period,
  input  logic          i_intl,
  input  logic          i_init_en,
  input  logic [DW-1:0] i_init_val,
  output logic [DW-1:0] o_set_point,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_abort,
  output logic [1:0]    o_state
`ifdef SP_RAMP_DBG_EN
  ,
  output logic [CW-1:0] o_dbg_cnt,
  output logic [DW:0]   o_dbg_diff,
  output logic [DW-1:0] o_dbg_target
`endif
);

  state_t        state_q, state_d;
  logic [DW-1:0] sp_q, sp_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] step_q, step_d;
  logic [CW-1:0] period_q, period_d;
  logic          abort_q, abort_d;

  logic          cnt_clear;
  logic          cnt_en;
  logic          expired;

  logic signed [DW:0] diff;
  logic [DW:0]        diff_abs;
  logic               close_enough;

  sp_ramp_tick #(.CW(CW)) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (cnt_clear),
    .i_enable  (cnt_en),
    .i_period  (period_q),
    .o_expired (expired)
`ifdef SP_RAMP_DBG_EN
    ,
    .o_cnt     (o_dbg_cnt)
`endif
  );

  // Sign-extend one bit so target - set-point can never wrap.
  assign diff         = $signed({target_q[DW-1], target_q}) - $signed({sp_q[DW-1], sp_q});
  assign diff_abs     = diff[DW] ? (~diff + 1'b1) : diff;
  assign close_enough = (step_q == '0) || (diff_abs <= {1'b0, step_q});

`ifdef SP_RAMP_DBG_EN
  logic [DW:0] dbg_diff_q, dbg_diff_d;
`endif

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    target_d  = target_q;
    step_d    = step_q;
    period_d  = period_q;
    abort_d   = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
`ifdef SP_RAMP_DBG_EN
    dbg_diff_d = dbg_diff_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_init_en) begin
          sp_d = i_init_val;
        end
        if (i_start && !i_intl) begin
          target_d  = i_target;
          step_d    = i_step;
          period_d  = i_period;
          cnt_clear = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT, STEP: begin
        // Interlock beats retarget, retarget beats the normal update.
        if (i_intl) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (i_start) begin
          target_d  = i_target;
          step_d    = i_step;
          period_d  = i_period;
          cnt_clear = 1'b1;
          state_d   = WAIT;
        end else if (state_q == WAIT) begin
          cnt_en = 1'b1;
          if (expired) begin
            state_d = STEP;
          end
        end else begin
`ifdef SP_RAMP_DBG_EN
          dbg_diff_d = diff;
`endif
          if (close_enough) begin
            sp_d    = target_q;
            state_d = DONE;
          end else begin
            sp_d      = diff[DW] ? (sp_q - step_q) : (sp_q + step_q);
            cnt_clear = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      target_q <= '0;
      step_q   <= '0;
      period_q <= '0;
      abort_q  <= 1'b0;
`ifdef SP_RAMP_DBG_EN
      dbg_diff_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      target_q <= target_d;
      step_q   <= step_d;
      period_q <= period_d;
      abort_q  <= abort_d;
`ifdef SP_RAMP_DBG_EN
      dbg_diff_q <= dbg_diff_d;
`endif
    end
  end

  assign o_set_point = sp_q;
  assign o_busy      = (state_q == WAIT) || (state_q == STEP);
  assign o_done      = (state_q == DONE);
  assign o_abort     = abort_q;
  assign o_state     = state_q;

`ifdef SP_RAMP_DBG_EN
  assign o_dbg_diff   = dbg_diff_q;
  assign o_dbg_target = target_q;
`endif

endmodule

// File: tb/tb_sp_ramp_gen.sv
// Scoreboard bench for sp_ramp_gen: expected set-point updates (value and cycle) are queued at start.
module tb_sp_ramp_gen;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_target = '0;
  logic [31:0] i_step = '0;
  logic [31:0] i_period = '0;
  logic        i_intl = 1'b0;
  logic        i_init_en = 1'b0;
  logic [31:0] i_init_val = '0;
  logic [31:0] o_set_point;
  logic        o_busy;
  logic        o_done;
  logic        o_abort;
  logic [1:0]  o_state;

  sp_ramp_gen #(.DW(32), .CW(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_target    (i_target),
    .i_step      (i_step),
    .i_period    (i_period),
    .i_intl      (i_intl),
    .i_init_en   (i_init_en),
    .i_init_val  (i_init_val),
    .o_set_point (o_set_point),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_abort     (o_abort),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc;
  int          done_cnt;
  int          done_cyc;
  int          abort_cnt;
  logic [31:0] prev_sp;

  // Reference ramp: pushes each expected set-point change and the cycle it becomes visible.
  task automatic push_model(input longint from_v, input longint tgt, input longint stp,
                            input longint per, input int maxn);
    longint sp = from_v;
    longint d;
    longint ad;
    int     k = 0;
    exp_t   e;
    while (sp != tgt && k < maxn) begin
      d  = tgt - sp;
      ad = (d < 0) ? -d : d;
      if (stp == 0 || ad <= stp) sp = tgt;
      else sp = (d > 0) ? sp + stp : sp - stp;
      k++;
      e.val = 32'(sp);
      e.cyc = k * int'(per + 2) + 1;
      sb_q.push_back(e);
    end
  endtask

  task automatic start_ramp(input longint from_v, input longint tgt, input longint stp,
                            input longint per, input int maxn);
    push_model(from_v, tgt, stp, per, maxn);
    i_target  = 32'(tgt);
    i_step    = 32'(stp);
    i_period  = 32'(per);
    i_start   = 1'b1;
    cyc       = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    abort_cnt = 0;
    prev_sp   = o_set_point;
  endtask

  // Advance n cycles, sampling on the falling edge and popping the scoreboard on every change.
  task automatic watch(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_start   = 1'b0;
      i_init_en = 1'b0;
      cyc++;
      if (o_set_point !== prev_sp) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sp_unexpected: cycle %0d got %0d, required no change", cyc,
                   $signed(o_set_point));
        end else begin
          e = sb_q.pop_front();
          if (o_set_point !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL sp_update: got %0d at cycle %0d, required %0d at cycle %0d",
                     $signed(o_set_point), cyc, $signed(e.val), e.cyc);
          end else begin
            $display("update sp=%0d cycle=%0d", $signed(o_set_point), cyc);
          end
        end
        prev_sp = o_set_point;
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_abort === 1'b1) abort_cnt++;
    end
  endtask

  task automatic do_init(input logic [31:0] v);
    i_init_en  = 1'b1;
    i_init_val = v;
    @(posedge i_clk);
    @(negedge i_clk);
    i_init_en = 1'b0;
    checks++;
    if (o_set_point !== v) begin
      errors++;
      $display("FAIL init_load: got %0d, required %0d", $signed(o_set_point), $signed(v));
    end
  endtask

  task automatic finish_ramp(input string name, input int exp_done_cyc);
    checks++;
    if (done_cnt != 1 || done_cyc != exp_done_cyc) begin
      errors++;
      $display("FAIL %s_done: %0d pulses last at cycle %0d, required 1 at cycle %0d",
               name, done_cnt, done_cyc, exp_done_cyc);
    end
    checks++;
    if (o_busy !== 1'b0 || o_state !== 2'd0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_end: busy=%0b state=%0d pending=%0d, required 0/0/0",
               name, o_busy, o_state, sb_q.size());
    end
    $display("%s: done_cnt=%0d done_cycle=%0d", name, done_cnt, done_cyc);
    sb_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_set_point !== 32'd0 || o_state !== 2'd0 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sp=%0d state=%0d busy=%0b done=%0b abort=%0b, required all 0",
               o_set_point, o_state, o_busy, o_done, o_abort);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    $display("reset: released");
  endtask

  task automatic test_ramp_up();
    do_init(32'd0);
    start_ramp(0, 100, 30, 2, 100);
    watch(1);
    checks++;
    if (o_state !== 2'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ramp_up_wait: state=%0d busy=%0b, required 1/1", o_state, o_busy);
    end
    watch(19);
    finish_ramp("ramp_up", 17);
  endtask

  task automatic test_ramp_down();
    do_init(32'd1000);
    start_ramp(1000, -500, 400, 0, 100);
    watch(14);
    finish_ramp("ramp_down", 9);
  endtask

  task automatic test_step_zero();
    do_init(32'd0);
    start_ramp(0, 12345, 0, 5, 100);
    watch(14);
    finish_ramp("step_zero", 8);
  endtask

  task automatic test_interlock();
    do_init(32'd0);
    start_ramp(0, 1000, 100, 1, 3);
    watch(10);
    i_intl = 1'b1;
    watch(1);
    checks++;
    if (o_state !== 2'd0 || o_set_point !== 32'd300 || abort_cnt != 1) begin
      errors++;
      $display("FAIL intl_abort: state=%0d sp=%0d aborts=%0d, required 0/300/1",
               o_state, $signed(o_set_point), abort_cnt);
    end
    i_target = 32'd50;
    i_start  = 1'b1;
    watch(6);
    checks++;
    if (o_state !== 2'd0 || o_busy !== 1'b0 || o_set_point !== 32'd300 ||
        abort_cnt != 1 || done_cnt != 0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL intl_hold: state=%0d busy=%0b sp=%0d aborts=%0d dones=%0d, required 0/0/300/1/0",
               o_state, o_busy, $signed(o_set_point), abort_cnt, done_cnt);
    end
    $display("interlock: sp=%0d aborts=%0d dones=%0d", $signed(o_set_point), abort_cnt, done_cnt);
    i_intl = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    do_init(32'd0);
    start_ramp(0, 1000, 100, 1, 4);
    watch(14);
    checks++;
    if (o_state !== 2'd1 || o_set_point !== 32'd400 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL retarget_pre: state=%0d sp=%0d, required 1/400", o_state,
               $signed(o_set_point));
    end
    start_ramp(400, 0, 100, 1, 100);
    watch(16);
    finish_ramp("retarget", 13);
  endtask

  task automatic test_async_reset();
    do_init(32'd500);
    start_ramp(500, 1000, 100, 3, 1);
    watch(8);
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_set_point !== 32'd0 || o_state !== 2'd0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sp=%0d state=%0d busy=%0b, required 0/0/0",
               $signed(o_set_point), o_state, o_busy);
    end
    sb_q.delete();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    do_init(32'd77);
    checks++;
    if (o_state !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_state: state=%0d, required 0", o_state);
    end
    $display("async_reset: sp after init=%0d", $signed(o_set_point));
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_step_zero();
    test_interlock();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
